// File: rtl/game_step_engine.sv
// Conway life engine (B3/S23): owns the displayed field, computes one row
// per clock into a shadow buffer and swaps it in with a single commit edge.
module game_step_engine #(
  parameter int FIELD_W = 40,
  parameter int FIELD_H = 30,
  parameter int WRAP    = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              step,
  input  logic                              wr_en,
  input  logic [5:0]                        wr_x,
  input  logic [4:0]                        wr_y,
  input  logic                              wr_val,
  input  logic                              clear,
  output logic [FIELD_H-1:0][FIELD_W-1:0]   game_field,
  output logic                              busy,
  output logic                              done,
  output logic [15:0]                       gen_count
);

  localparam int RW = (FIELD_H > 1) ? $clog2(FIELD_H) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_COMMIT
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [RW-1:0]                     r_row;
  logic [FIELD_H-1:0][FIELD_W-1:0]   r_next;

  logic [FIELD_W-1:0] w_up;
  logic [FIELD_W-1:0] w_mid;
  logic [FIELD_W-1:0] w_dn;
  logic [FIELD_W-1:0] w_ul;
  logic [FIELD_W-1:0] w_ur;
  logic [FIELD_W-1:0] w_ml;
  logic [FIELD_W-1:0] w_mr;
  logic [FIELD_W-1:0] w_dl;
  logic [FIELD_W-1:0] w_dr;
  logic [FIELD_W-1:0] w_row;
  logic [3:0]         w_cnt;
  logic               w_last;
  logic               w_wr_ok;

  // bit x of the result holds the neighbour at column x-1
  function automatic logic [FIELD_W-1:0] nb_l(
    input logic [FIELD_W-1:0] v
  );
    logic w_edge;
    w_edge = (WRAP != 0) ? v[FIELD_W-1] : 1'b0;
    return {v[FIELD_W-2:0], w_edge};
  endfunction

  // bit x of the result holds the neighbour at column x+1
  function automatic logic [FIELD_W-1:0] nb_r(
    input logic [FIELD_W-1:0] v
  );
    logic w_edge;
    w_edge = (WRAP != 0) ? v[0] : 1'b0;
    return {w_edge, v[FIELD_W-1:1]};
  endfunction

  assign w_last  = (r_row == RW'(FIELD_H - 1));
  assign w_wr_ok = wr_en
                && (int'(wr_x) < FIELD_W)
                && (int'(wr_y) < FIELD_H);

  always_comb begin
    w_mid = game_field[r_row];
    if (r_row == '0) begin
      w_up = (WRAP != 0) ? game_field[FIELD_H-1] : '0;
    end else begin
      w_up = game_field[r_row - RW'(1)];
    end
    if (w_last) begin
      w_dn = (WRAP != 0) ? game_field[0] : '0;
    end else begin
      w_dn = game_field[r_row + RW'(1)];
    end
  end

  assign w_ul = nb_l(w_up);
  assign w_ur = nb_r(w_up);
  assign w_ml = nb_l(w_mid);
  assign w_mr = nb_r(w_mid);
  assign w_dl = nb_l(w_dn);
  assign w_dr = nb_r(w_dn);

  always_comb begin
    w_row = '0;
    w_cnt = '0;
    for (int x = 0; x < FIELD_W; x++) begin
      w_cnt = 4'(w_ul[x]) + 4'(w_up[x]) + 4'(w_ur[x])
            + 4'(w_ml[x]) + 4'(w_mr[x])
            + 4'(w_dl[x]) + 4'(w_dn[x]) + 4'(w_dr[x]);
      w_row[x] = (w_cnt == 4'd3)
               | (w_mid[x] & (w_cnt == 4'd2));
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!clear && step) w_state_nx = S_CALC;
      end
      S_CALC: begin
        if (clear)       w_state_nx = S_IDLE;
        else if (w_last) w_state_nx = S_COMMIT;
      end
      S_COMMIT: w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_field <= '0;
      r_next     <= '0;
      r_row      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gen_count  <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (clear) begin
            game_field <= '0;
            gen_count  <= '0;
          end else if (step) begin
            busy  <= 1'b1;
            r_row <= '0;
          end else if (w_wr_ok) begin
            game_field[wr_y][wr_x] <= wr_val;
          end
        end
        S_CALC: begin
          if (clear) begin
            game_field <= '0;
            gen_count  <= '0;
            busy       <= 1'b0;
            r_row      <= '0;
          end else begin
            r_next[r_row] <= w_row;
            if (!w_last) r_row <= r_row + RW'(1);
          end
        end
        S_COMMIT: begin
          busy <= 1'b0;
          if (clear) begin
            game_field <= '0;
            gen_count  <= '0;
          end else begin
            game_field <= r_next;
            gen_count  <= gen_count + 16'd1;
            done       <= 1'b1;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_game_step_engine.sv
// Bench for game_step_engine: wrap and no-wrap instances checked every
// cycle against a whole-generation reference model plus literal pins.
module tb_game_step_engine;

  localparam int W = 40;
  localparam int H = 30;

  typedef bit fld_t [H][W];
  typedef logic [H-1:0][W-1:0] pf_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step = 1'b0;
  logic wr_en = 1'b0;
  logic wr_val = 1'b0;
  logic clear = 1'b0;
  logic [5:0] wr_x = '0;
  logic [4:0] wr_y = '0;

  pf_t f1, f0;
  logic busy1, busy0, done1, done0;
  logic [15:0] gen1, gen0;

  always #5 clk = ~clk;

  game_step_engine #(.FIELD_W(W), .FIELD_H(H), .WRAP(1)) u1 (
    .clk(clk), .rst(rst), .step(step), .wr_en(wr_en),
    .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val), .clear(clear),
    .game_field(f1), .busy(busy1), .done(done1), .gen_count(gen1)
  );

  game_step_engine #(.FIELD_W(W), .FIELD_H(H), .WRAP(0)) u0 (
    .clk(clk), .rst(rst), .step(step), .wr_en(wr_en),
    .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val), .clear(clear),
    .game_field(f0), .busy(busy0), .done(done0), .gen_count(gen0)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_field(string name, pf_t act, pf_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int y = 0; y < H; y++) begin
        if (act[y] !== exp[y]) begin
          $display("FAIL %s row=%0d actual=%h required=%h",
                   name, y, act[y], exp[y]);
          break;
        end
      end
    end
  endtask

  // ---------------- reference model ----------------
  fld_t m_f [2];
  fld_t m_nx [2];
  fld_t z;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  logic [15:0] m_gen = '0;
  int m_cnt = 0;

  function automatic fld_t life(fld_t f, bit wrap);
    fld_t n;
    int c, yy, xx;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        c = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dy != 0 || dx != 0) begin
              yy = y + dy;
              xx = x + dx;
              if (wrap) begin
                yy = (yy + H) % H;
                xx = (xx + W) % W;
                c += int'(f[yy][xx]);
              end else if (yy >= 0 && yy < H && xx >= 0 && xx < W) begin
                c += int'(f[yy][xx]);
              end
            end
          end
        end
        n[y][x] = (c == 3) || (f[y][x] && c == 2);
      end
    end
    return n;
  endfunction

  function automatic pf_t pk(fld_t f);
    pf_t p;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        p[y][x] = f[y][x];
    return p;
  endfunction

  function automatic pf_t glider(int dx, int dy);
    pf_t g;
    int xs [5];
    int ys [5];
    xs = '{1, 2, 0, 1, 2};
    ys = '{0, 1, 2, 2, 2};
    g = '0;
    for (int i = 0; i < 5; i++)
      g[(ys[i] + dy) % H][(xs[i] + dx) % W] = 1'b1;
    return g;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_f[0] <= z;
      m_f[1] <= z;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_gen <= '0;
      m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (clear) begin
          m_busy <= 1'b0;
          m_f[0] <= z;
          m_f[1] <= z;
          m_gen <= '0;
        end else if (m_cnt == H) begin
          m_f[0] <= m_nx[0];
          m_f[1] <= m_nx[1];
          m_gen <= m_gen + 16'd1;
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (clear) begin
        m_f[0] <= z;
        m_f[1] <= z;
        m_gen <= '0;
      end else if (step) begin
        m_nx[0] <= life(m_f[0], 1'b0);
        m_nx[1] <= life(m_f[1], 1'b1);
        m_busy <= 1'b1;
        m_cnt <= 0;
      end else if (wr_en && int'(wr_x) < W && int'(wr_y) < H) begin
        m_f[0][wr_y][wr_x] <= wr_val;
        m_f[1][wr_y][wr_x] <= wr_val;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_w1", busy1, m_busy);
      chk("busy_w0", busy0, m_busy);
      chk("done_w1", done1, m_done);
      chk("done_w0", done0, m_done);
      chk("gen_w1", gen1, m_gen);
      chk("gen_w0", gen0, m_gen);
      chk_field("field_w1", f1, pk(m_f[1]));
      chk_field("field_w0", f0, pk(m_f[0]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(int x, int y, bit v);
    wr_en = 1'b1;
    wr_x = 6'(x);
    wr_y = 5'(y);
    wr_val = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic blinker();
    wr(10, 5, 1'b1);
    wr(11, 5, 1'b1);
    wr(12, 5, 1'b1);
  endtask

  task automatic step_wait(output int lat);
    step = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      step = 1'b0;
      lat++;
    end while (!done1 && lat < 100);
  endtask

  int lat, n, k, dn;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", busy1, 0);
    chk("rst_gen", gen1, 0);
    chk("rst_pop", $countones(f1), 0);

    // blinker
    blinker();
    step_wait(lat);
    chk("blink_latency", lat, 32);
    chk("blink_vert", f1[4][11] & f1[5][11] & f1[6][11], 1);
    chk("blink_pop", $countones(f1), 3);
    chk("blink_gen", gen1, 1);
    chk("model_blink", m_f[1][6][11], 1);
    step_wait(lat);
    chk("blink2_horiz", f1[5][10] & f1[5][11] & f1[5][12], 1);
    chk("blink2_pop", $countones(f1), 3);
    chk("blink2_gen", gen1, 2);

    // block across the corner
    do_clear();
    wr(39, 29, 1'b1);
    wr(0, 29, 1'b1);
    wr(39, 0, 1'b1);
    wr(0, 0, 1'b1);
    step_wait(lat);
    chk("block_w1_pop", $countones(f1), 4);
    chk("block_w1_corner", f1[29][39] & f1[0][0], 1);
    chk("block_w0_pop", $countones(f0), 0);

    // glider: 4 single steps, then 156 more with step held high
    do_clear();
    wr(1, 0, 1'b1);
    wr(2, 1, 1'b1);
    wr(0, 2, 1'b1);
    wr(1, 2, 1'b1);
    wr(2, 2, 1'b1);
    chk_field("glider0", f1, glider(0, 0));
    repeat (4) step_wait(lat);
    chk_field("glider4", f1, glider(1, 1));
    chk_field("model_glider4", pk(m_f[1]), glider(1, 1));
    step = 1'b1;
    n = 0;
    k = 0;
    while (n < 156 && k < 6000) begin
      @(negedge clk);
      k++;
      if (done1) begin
        n++;
        if (n == 156) step = 1'b0;
      end
    end
    step = 1'b0;
    chk("hold_dones", n, 156);
    chk("hold_cycles", k, 156 * 32);
    chk("glider_gen", gen1, 160);
    chk_field("glider160", f1, glider(0, 10));

    // step and write while busy are dropped
    do_clear();
    step = 1'b1;
    dn = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      step = (i == 5);
      wr_en = (i == 10);
      wr_x = '0;
      wr_y = '0;
      wr_val = 1'b1;
      if (done1) dn++;
    end
    wr_en = 1'b0;
    step = 1'b0;
    chk("busy_dones", dn, 1);
    chk("busy_cell00", f1[0][0], 0);
    chk("busy_gen", gen1, 1);

    // clear mid-CALC
    do_clear();
    blinker();
    step = 1'b1;
    dn = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      step = 1'b0;
      clear = (i == 10);
      if (i == 11) chk("clr_busy", busy1, 0);
      if (done1) dn++;
    end
    clear = 1'b0;
    chk("clr_dones", dn, 0);
    chk("clr_gen", gen1, 0);
    chk("clr_pop", $countones(f1), 0);

    // async reset in COMMIT
    blinker();
    step = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      step = 1'b0;
    end
    chk("commit_busy", busy1, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy1, 0);
    chk("arst_done", done1, 0);
    chk("arst_gen", gen1, 0);
    chk("arst_pop_w1", $countones(f1), 0);
    chk("arst_pop_w0", $countones(f0), 0);
    @(negedge clk);
    rst = 1'b0;
    wr(45, 3, 1'b1);
    wr(5, 31, 1'b1);
    chk("oor_pop", $countones(f1), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      clear = ($urandom_range(0, 63) == 0);
      step = ($urandom_range(0, 15) == 0);
      wr_en = 1'($urandom_range(0, 1));
      wr_x = 6'($urandom_range(0, 47));
      wr_y = 5'($urandom_range(0, 31));
      wr_val = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    clear = 1'b0;
    step = 1'b0;
    wr_en = 1'b0;
    repeat (40) @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
